// File: rtl/quad_pkg.sv
// Shared types and helpers for quadrature decoding: the step classification enum
// and the Gray-code ordering of the A/B phases.
package quad_pkg;

    typedef enum logic [1:0] {
        STEP_NONE    = 2'b00,
        STEP_UP      = 2'b01,
        STEP_DOWN    = 2'b10,
        STEP_ILLEGAL = 2'b11
    } quad_step_t;

    // {a,b} codes in up-count order, slot 0 in the low bits: 00, 01, 11, 10
    localparam logic [7:0] GRAY_SEQ = {2'b10, 2'b11, 2'b01, 2'b00};

    // Position of an {a,b} code within the up-count cycle (0..3)
    function automatic logic [1:0] gray_phase(input logic [1:0] code);
        logic [1:0] phase;
        phase = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (GRAY_SEQ[2*i +: 2] == code) begin
                phase = 2'(i);
            end
        end
        return phase;
    endfunction

endpackage

// File: rtl/quad_step_decode.sv
// Combinational classifier for one A/B sample pair: no step, up, down, or an
// illegal double-bit change. Shared with the multi-axis encoder block.
module quad_step_decode
    import quad_pkg::*;
(
    input  logic [1:0] ab_prev,
    input  logic [1:0] cur,
    output quad_step_t step
);

    logic [1:0] phase_prev;
    logic [1:0] phase_cur;
    logic [1:0] phase_diff;

    assign phase_prev = gray_phase(ab_prev);
    assign phase_cur  = gray_phase(cur);
    // Modulo-4 distance around the Gray cycle; a distance of 2 means both bits flipped
    assign phase_diff = phase_cur - phase_prev;

    always_comb begin
        step = STEP_NONE;
        case (phase_diff)
            2'd0:    step = STEP_NONE;
            2'd1:    step = STEP_UP;
            2'd3:    step = STEP_DOWN;
            default: step = STEP_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/quad_decoder.sv
// x4 quadrature position counter with sticky illegal-transition flag and an
// armed index latch that captures and zeroes the position on a Z rising edge.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a,
    input  logic                    b,
    input  logic                    z,
    input  logic                    index_arm,
    input  logic                    err_clr,
    output logic signed [WIDTH-1:0] position,
    output logic                    dir,
    output logic                    index_armed,
    output logic signed [WIDTH-1:0] index_pos,
    output logic                    index_seen,
    output logic                    error
);

    logic [1:0]              ab_prev_reg,     ab_prev_next;
    logic                    prev_valid_reg,  prev_valid_next;
    logic                    z_prev_reg,      z_prev_next;
    logic signed [WIDTH-1:0] position_reg,    position_next;
    logic signed [WIDTH-1:0] index_pos_reg,   index_pos_next;
    logic                    dir_reg,         dir_next;
    logic                    armed_reg,       armed_next;
    logic                    seen_reg,        seen_next;
    logic                    error_reg,       error_next;

    logic [1:0]              cur;
    quad_step_t              step;
    logic signed [WIDTH-1:0] delta;
    logic signed [WIDTH-1:0] sum;
    logic                    z_rise;
    logic                    take_index;

    assign cur = {a, b};

    quad_step_decode u_step_decode (
        .ab_prev (ab_prev_reg),
        .cur     (cur),
        .step    (step)
    );

    always_comb begin
        delta = '0;
        case (step)
            STEP_UP:   delta = {{(WIDTH-1){1'b0}}, 1'b1};
            STEP_DOWN: delta = '1;
            default:   delta = '0;
        endcase
    end

    // Two's-complement add wraps naturally at the WIDTH boundary
    assign sum        = position_reg + delta;
    assign z_rise     = z & ~z_prev_reg;
    assign take_index = prev_valid_reg & z_rise & armed_reg;

    always_comb begin
        ab_prev_next    = cur;
        z_prev_next     = z;
        prev_valid_next = 1'b1;
        position_next   = position_reg;
        index_pos_next  = index_pos_reg;
        dir_next        = dir_reg;
        seen_next       = 1'b0;
        error_next      = error_reg;
        armed_next      = armed_reg;

        if (prev_valid_reg) begin
            if (take_index) begin
                index_pos_next = sum;
                position_next  = '0;
                seen_next      = 1'b1;
            end else begin
                position_next  = sum;
            end

            if (step == STEP_UP) begin
                dir_next = 1'b1;
            end else if (step == STEP_DOWN) begin
                dir_next = 1'b0;
            end
        end

        // Set beats clear when both land in the same cycle
        if (prev_valid_reg && step == STEP_ILLEGAL) begin
            error_next = 1'b1;
        end else if (err_clr) begin
            error_next = 1'b0;
        end

        // A fresh arm request wins over the disarm caused by a taken edge
        if (index_arm) begin
            armed_next = 1'b1;
        end else if (take_index) begin
            armed_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ab_prev_reg    <= 2'b00;
            prev_valid_reg <= 1'b0;
            z_prev_reg     <= 1'b0;
            position_reg   <= '0;
            index_pos_reg  <= '0;
            dir_reg        <= 1'b0;
            armed_reg      <= 1'b0;
            seen_reg       <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            ab_prev_reg    <= ab_prev_next;
            prev_valid_reg <= prev_valid_next;
            z_prev_reg     <= z_prev_next;
            position_reg   <= position_next;
            index_pos_reg  <= index_pos_next;
            dir_reg        <= dir_next;
            armed_reg      <= armed_next;
            seen_reg       <= seen_next;
            error_reg      <= error_next;
        end
    end

    assign position    = position_reg;
    assign dir         = dir_reg;
    assign index_armed = armed_reg;
    assign index_pos   = index_pos_reg;
    assign index_seen  = seen_reg;
    assign error       = error_reg;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder (WIDTH=8): a successor-table model is checked
// every cycle, and hand-computed literal expectations pin the model at milestones.
module tb_quad_decoder;

    localparam int W = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                a = 1'b1, b = 1'b1, z = 1'b0;
    logic                index_arm = 1'b0, err_clr = 1'b0;
    logic signed [W-1:0] position, index_pos;
    logic                dir, index_armed, index_seen, error;

    int vectors = 0;
    int miscompares = 0;

    // Up-count successor and predecessor of each {a,b} code
    int up_next [4] = '{1, 3, 0, 2};
    int dn_next [4] = '{2, 0, 3, 1};

    quad_decoder #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .z           (z),
        .index_arm   (index_arm),
        .err_clr     (err_clr),
        .position    (position),
        .dir         (dir),
        .index_armed (index_armed),
        .index_pos   (index_pos),
        .index_seen  (index_seen),
        .error       (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_pos, m_ipos;
    bit m_dir, m_armed, m_seen, m_err, m_valid, m_prev_z;
    int m_prev_ab;

    function automatic int wrap8(input int v);
        int r;
        r = ((v % 256) + 256) % 256;
        if (r > 127) r -= 256;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        int c, stp;
        bit ill;
        if (rst) begin
            m_pos = 0; m_ipos = 0; m_dir = 0; m_armed = 0; m_seen = 0;
            m_err = 0; m_valid = 0; m_prev_z = 0; m_prev_ab = 0;
        end else begin
            c = {30'd0, a, b};
            m_seen = 0;
            if (!m_valid) begin
                m_valid = 1;
                if (index_arm) m_armed = 1;
                if (err_clr) m_err = 0;
            end else begin
                stp = 0; ill = 0;
                if (c == m_prev_ab) stp = 0;
                else if (c == up_next[m_prev_ab]) stp = 1;
                else if (c == dn_next[m_prev_ab]) stp = -1;
                else ill = 1;
                if (ill) m_err = 1;
                else if (err_clr) m_err = 0;
                if (stp != 0) m_dir = (stp > 0);
                if (z && !m_prev_z && m_armed) begin
                    m_ipos = wrap8(m_pos + stp);
                    m_pos = 0;
                    m_seen = 1;
                    m_armed = 0;
                end else begin
                    m_pos = wrap8(m_pos + stp);
                end
                if (index_arm) m_armed = 1;
            end
            m_prev_ab = c;
            m_prev_z = z;
        end
    end

    // Every-cycle comparison on the falling edge
    always @(negedge clk) begin
        chk("position",    int'(position),  m_pos);
        chk("dir",         int'(dir),       int'(m_dir));
        chk("index_armed", int'(index_armed), int'(m_armed));
        chk("index_pos",   int'(index_pos), m_ipos);
        chk("index_seen",  int'(index_seen), int'(m_seen));
        chk("error",       int'(error),     int'(m_err));
    end

    // ---------------- stimulus ----------------
    int ab_cur = 3;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_ab(input int v);
        ab_cur = v;
        {a, b} = 2'(v);
    endtask

    task automatic step_up(input int hold);
        drive_ab(up_next[ab_cur]);
        repeat (hold) tick();
    endtask

    task automatic step_dn(input int hold);
        drive_ab(dn_next[ab_cur]);
        repeat (hold) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: release reset with {a,b}=11 held; first sample not counted
        drive_ab(3);
        repeat (2) tick();
        chk("reset_position", int'(position), 0);
        chk("reset_error", int'(error), 0);
        rst = 1'b0;
        repeat (5) tick();
        chk("t1_position", int'(position), 0);
        chk("t1_error", int'(error), 0);

        // Re-reset with {a,b}=00 so the up sequence starts from 00
        rst = 1'b1;
        drive_ab(0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // 2: three full up cycles, then five down steps
        for (int i = 0; i < 12; i++) step_up(4);
        chk("t2_up_position", int'(position), 12);
        chk("t2_up_dir", int'(dir), 1);
        for (int i = 0; i < 5; i++) step_dn(4);
        chk("t2_dn_position", int'(position), 7);
        chk("t2_dn_dir", int'(dir), 0);

        // 3: wrap at the 8-bit boundary
        for (int i = 0; i < 120; i++) step_up(2);
        chk("t3_max", int'(position), 127);
        step_up(2);
        chk("t3_wrap_up", int'(position), -128);
        step_dn(2);
        chk("t3_wrap_dn", int'(position), 127);
        chk("t3_error", int'(error), 0);

        // 4: armed index edge coinciding with an up step at position 40
        for (int i = 0; i < 87; i++) step_dn(2);
        chk("t4_start", int'(position), 40);
        index_arm = 1'b1;
        tick();
        index_arm = 1'b0;
        chk("t4_armed", int'(index_armed), 1);
        z = 1'b1;
        step_up(1);
        chk("t4_position", int'(position), 0);
        chk("t4_index_pos", int'(index_pos), 41);
        chk("t4_seen", int'(index_seen), 1);
        chk("t4_disarmed", int'(index_armed), 0);
        tick();
        chk("t4_seen_once", int'(index_seen), 0);
        z = 1'b0;
        repeat (2) tick();
        z = 1'b1;
        tick();
        chk("t4_second_seen", int'(index_seen), 0);
        chk("t4_second_pos", int'(position), 0);
        chk("t4_second_ipos", int'(index_pos), 41);
        z = 1'b0;
        tick();

        // 5: illegal transition, clear, clear colliding with illegal
        step_dn(2);                      // 01 -> 00, position -1
        drive_ab(3);                     // 00 -> 11 illegal
        tick();
        chk("t5_error_set", int'(error), 1);
        chk("t5_pos_held", int'(position), -1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t5_error_clr", int'(error), 0);
        step_dn(2);                      // 11 -> 01, position -2
        drive_ab(2);                     // 01 -> 10 illegal with clear
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t5_set_wins", int'(error), 1);
        chk("t5_pos_held2", int'(position), -2);
        tick();

        // 6: asynchronous reset while armed at position 25
        for (int i = 0; i < 27; i++) step_up(2);
        chk("t6_start", int'(position), 25);
        index_arm = 1'b1;
        tick();
        index_arm = 1'b0;
        chk("t6_armed", int'(index_armed), 1);
        #1;
        drive_ab(1);
        rst = 1'b1;
        #1;
        chk("t6_async_pos", int'(position), 0);
        chk("t6_async_armed", int'(index_armed), 0);
        chk("t6_async_dir", int'(dir), 0);
        chk("t6_async_error", int'(error), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_first_sample", int'(position), 0);
        chk("t6_not_armed", int'(index_armed), 0);
        step_up(2);                      // 01 -> 11
        chk("t6_counts_again", int'(position), 1);
        chk("t6_dir", int'(dir), 1);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
